// File: rtl/cache_tag_ctrl_n.sv
// Set-associative tag controller with true-LRU replacement and a one-request-at-a-time handshake.
// Optional whole-cache invalidate is enabled by defining CACHE_FLUSH_EN.
module cache_tag_ctrl_n #(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = 8,
  parameter int WAYS        = 4,
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] index,
  input  logic [TAG_WIDTH-1:0]   tag,
  input  logic                   it_valid,
  output logic                   it_ready,
  output logic                   hit_miss,
  output logic [WAY_W-1:0]       col,
  output logic                   hm_valid,
`ifdef CACHE_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   hm_ready
);

  localparam int SETS = 2 ** INDEX_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_FLUSH} state_t;

  state_t                 state_q;
  logic                   it_ready_q;
  logic                   hm_valid_q;
  logic                   hit_miss_q;
  logic [WAY_W-1:0]       col_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0]   req_tag_q;
`ifdef CACHE_FLUSH_EN
  logic [INDEX_WIDTH-1:0] flush_idx_q;
`endif

  logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
  logic                 valid_q [SETS][WAYS];
  logic [WAY_W-1:0]     age_q   [SETS][WAYS];

  logic             hit_d;
  logic [WAY_W-1:0] hit_way_s;
  logic             inv_found_s;
  logic [WAY_W-1:0] inv_way_s;
  logic [WAY_W-1:0] lru_way_s;
  logic [WAY_W-1:0] col_d;
  logic [WAY_W-1:0] acc_age_s;
  logic [WAY_W-1:0] age_d [WAYS];

  // Lookup of the captured set: hit detection, victim choice and the post-access ages.
  always_comb begin
    hit_d       = 1'b0;
    hit_way_s   = '0;
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    lru_way_s   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_d && valid_q[idx_q][w] && (tag_q[idx_q][w] == req_tag_q)) begin
        hit_d     = 1'b1;
        hit_way_s = WAY_W'(w);
      end else begin
        hit_d = hit_d;
      end
      if (age_q[idx_q][w] == WAY_W'(WAYS - 1)) begin
        lru_way_s = WAY_W'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    // Scan downward so the lowest-numbered invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_W'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
    end
    if (hit_d) begin
      col_d = hit_way_s;
    end else if (inv_found_s) begin
      col_d = inv_way_s;
    end else begin
      col_d = lru_way_s;
    end
    acc_age_s = age_q[idx_q][col_d];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == col_d) begin
        age_d[w] = '0;
      end else if (age_q[idx_q][w] < acc_age_s) begin
        age_d[w] = age_q[idx_q][w] + WAY_W'(1);
      end else begin
        age_d[w] = age_q[idx_q][w];
      end
    end
  end

  // Control FSM, registered outputs and tag/valid/age array updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      it_ready_q <= 1'b1;
      hm_valid_q <= 1'b0;
      hit_miss_q <= 1'b0;
      col_q      <= '0;
      idx_q      <= '0;
      req_tag_q  <= '0;
`ifdef CACHE_FLUSH_EN
      flush_idx_q <= '0;
`endif
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
`ifdef CACHE_FLUSH_EN
          if (flush) begin
            state_q     <= S_FLUSH;
            it_ready_q  <= 1'b0;
            flush_idx_q <= '0;
          end else
`endif
          if (it_valid) begin
            idx_q      <= index;
            req_tag_q  <= tag;
            state_q    <= S_LOOKUP;
            it_ready_q <= 1'b0;
          end
        end
        S_LOOKUP: begin
          hit_miss_q <= hit_d;
          col_q      <= col_d;
          hm_valid_q <= 1'b1;
          state_q    <= S_RESP;
          if (!hit_d) begin
            tag_q[idx_q][col_d]   <= req_tag_q;
            valid_q[idx_q][col_d] <= 1'b1;
          end
          for (int w = 0; w < WAYS; w++) begin
            age_q[idx_q][w] <= age_d[w];
          end
        end
        S_RESP: begin
          if (hm_ready) begin
            hm_valid_q <= 1'b0;
            state_q    <= S_IDLE;
            it_ready_q <= 1'b1;
          end
        end
`ifdef CACHE_FLUSH_EN
        S_FLUSH: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[flush_idx_q][w] <= 1'b0;
            age_q[flush_idx_q][w]   <= WAY_W'(w);
          end
          if (flush_idx_q == {INDEX_WIDTH{1'b1}}) begin
            state_q    <= S_IDLE;
            it_ready_q <= 1'b1;
          end else begin
            flush_idx_q <= flush_idx_q + INDEX_WIDTH'(1);
          end
        end
`endif
        default: begin
          state_q    <= S_IDLE;
          it_ready_q <= 1'b1;
          hm_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign it_ready = it_ready_q;
  assign hm_valid = hm_valid_q;
  assign hit_miss = hit_miss_q;
  assign col      = col_q;

endmodule

// File: tb/tb_cache_tag_ctrl_n.sv
// Directed-vector bench for cache_tag_ctrl_n (WAYS=4, INDEX_WIDTH=6, TAG_WIDTH=8).
// Flush vectors run only when CACHE_FLUSH_EN is defined.
module tb_cache_tag_ctrl_n;

  logic       clk;
  logic       rst;
  logic [5:0] index;
  logic [7:0] tag;
  logic       it_valid;
  logic       it_ready;
  logic       hit_miss;
  logic [1:0] col;
  logic       hm_valid;
  logic       hm_ready;
`ifdef CACHE_FLUSH_EN
  logic       flush;
`endif

  int n_vec;
  int n_err;

  cache_tag_ctrl_n #(.INDEX_WIDTH(6), .TAG_WIDTH(8), .WAYS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .index    (index),
    .tag      (tag),
    .it_valid (it_valid),
    .it_ready (it_ready),
    .hit_miss (hit_miss),
    .col      (col),
    .hm_valid (hm_valid),
`ifdef CACHE_FLUSH_EN
    .flush    (flush),
`endif
    .hm_ready (hm_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request with hm_ready high: accept, lookup, response, back to idle.
  task automatic do_req(input string name, input logic [5:0] idx, input logic [7:0] tg,
                        input logic exp_hit, input logic [1:0] exp_col);
    check_vec({name, ".rdy"}, 32'(it_ready), 32'd1);
    index    = idx;
    tag      = tg;
    it_valid = 1'b1;
    step();
    it_valid = 1'b0;
    check_vec({name, ".lkup_vld"}, 32'(hm_valid), 32'd0);
    step();
    check_vec({name, ".vld"}, 32'(hm_valid), 32'd1);
    check_vec({name, ".hit"}, 32'(hit_miss), 32'(exp_hit));
    check_vec({name, ".col"}, 32'(col), 32'(exp_col));
    step();
    check_vec({name, ".idle"}, 32'(it_ready), 32'd1);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst      = 1'b1;
    index    = 6'd0;
    tag      = 8'd0;
    it_valid = 1'b0;
    hm_ready = 1'b1;
`ifdef CACHE_FLUSH_EN
    flush    = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check_vec("rst.rdy", 32'(it_ready), 32'd1);
    check_vec("rst.vld", 32'(hm_valid), 32'd0);
    check_vec("rst.hit", 32'(hit_miss), 32'd0);
    check_vec("rst.col", 32'(col), 32'd0);

    do_req("s5a", 6'd5, 8'h12, 1'b0, 2'd0);
    do_req("s5b", 6'd5, 8'h12, 1'b1, 2'd0);

    // Set 3 fill then LRU replacement; ages end at [1,0,3,2] before B0.
    do_req("s3a0", 6'd3, 8'hA0, 1'b0, 2'd0);
    do_req("s3b0", 6'd3, 8'hB0, 1'b0, 2'd1);
    do_req("s3c0", 6'd3, 8'hC0, 1'b0, 2'd2);
    do_req("s3d0", 6'd3, 8'hD0, 1'b0, 2'd3);
    do_req("s3a0h", 6'd3, 8'hA0, 1'b1, 2'd0);
    do_req("s3e0", 6'd3, 8'hE0, 1'b0, 2'd1);
    do_req("s3b0m", 6'd3, 8'hB0, 1'b0, 2'd2);

    // Set independence: set 7 traffic must not age set 8.
    do_req("s7", 6'd7, 8'h11, 1'b0, 2'd0);
    do_req("s8", 6'd8, 8'h11, 1'b0, 2'd0);
    do_req("s7h", 6'd7, 8'h11, 1'b1, 2'd0);
    do_req("s8b", 6'd8, 8'h22, 1'b0, 2'd1);
    do_req("s8c", 6'd8, 8'h33, 1'b0, 2'd2);
    do_req("s8d", 6'd8, 8'h44, 1'b0, 2'd3);
    do_req("s8lru", 6'd8, 8'h55, 1'b0, 2'd0);
    do_req("s7h2", 6'd7, 8'h11, 1'b1, 2'd0);

    // Back-pressure in RESP with ignored request pulses.
    hm_ready = 1'b0;
    index    = 6'd10;
    tag      = 8'h5A;
    it_valid = 1'b1;
    step();
    it_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_vec("bp.vld", 32'(hm_valid), 32'd1);
      check_vec("bp.hit", 32'(hit_miss), 32'd0);
      check_vec("bp.col", 32'(col), 32'd0);
      check_vec("bp.rdy", 32'(it_ready), 32'd0);
      index    = 6'd20;
      tag      = 8'h77;
      it_valid = i[0] ? 1'b0 : 1'b1;
      step();
    end
    it_valid = 1'b0;
    check_vec("bp.vld5", 32'(hm_valid), 32'd1);
    hm_ready = 1'b1;
    step();
    check_vec("bp.rel_vld", 32'(hm_valid), 32'd0);
    check_vec("bp.rel_rdy", 32'(it_ready), 32'd1);
    do_req("bp.nodup", 6'd20, 8'h77, 1'b0, 2'd0);

    // Reset while a response is pending.
    hm_ready = 1'b0;
    index    = 6'd12;
    tag      = 8'h34;
    it_valid = 1'b1;
    step();
    it_valid = 1'b0;
    step();
    check_vec("rr.vld_pre", 32'(hm_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_vec("rr.vld", 32'(hm_valid), 32'd0);
    check_vec("rr.rdy", 32'(it_ready), 32'd1);
    hm_ready = 1'b1;
    do_req("rr.s5", 6'd5, 8'h12, 1'b0, 2'd0);
    do_req("rr.s3", 6'd3, 8'hA0, 1'b0, 2'd0);

`ifdef CACHE_FLUSH_EN
    begin
      int cnt;
      do_req("fl.s0", 6'd0, 8'h09, 1'b0, 2'd0);
      do_req("fl.s63", 6'd63, 8'h09, 1'b0, 2'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      cnt = 0;
      while (it_ready == 1'b0 && cnt < 200) begin
        cnt++;
        step();
      end
      check_vec("fl.cycles", 32'(cnt), 32'd64);
      do_req("fl.s0m", 6'd0, 8'h09, 1'b0, 2'd0);
      do_req("fl.s63m", 6'd63, 8'h09, 1'b0, 2'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
